// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcodes, ALU op encoding and immediate formats
package rv_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        return (opc == OPC_LUI || opc == OPC_AUIPC) ? IMM_U :
               opc == OPC_JAL    ? IMM_J :
               opc == OPC_BRANCH ? IMM_B :
               opc == OPC_STORE  ? IMM_S : IMM_I;
    endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: instruction word to sign-extended immediate (WIDTH >= 32)
module imm_gen
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    output logic [WIDTH-1:0] imm
);
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, sel;
    imm_fmt_e fmt;
    assign fmt   = imm_fmt(instr[6:0]);
    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign sel   = fmt == IMM_S ? s_imm :
                   fmt == IMM_B ? b_imm :
                   fmt == IMM_U ? u_imm :
                   fmt == IMM_J ? j_imm : i_imm;
    assign imm   = {{(WIDTH-31){sel[31]}}, sel[30:0]};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with x0 forcing, write-back bypass, load-use bubble and registered ID/EX bundle
module decode_stage
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [WIDTH-1:0] if_pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [WIDTH-1:0] rs1_rdata,
    input  logic [WIDTH-1:0] rs2_rdata,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_rs1_val,
    output logic [WIDTH-1:0] id_rs2_val,
    output logic [WIDTH-1:0] id_imm,
    output logic [4:0]       id_rd,
    output logic [3:0]       id_alu_op,
    output logic [2:0]       id_funct3,
    output logic             id_wb_en,
    output logic             id_mem_rd,
    output logic             id_mem_wr,
    output logic             id_branch,
    output logic             id_jump,
    output logic             id_illegal
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
    logic legal, wb, hazard, accept;
    logic [WIDTH-1:0] imm, rs1_val, rs2_val;
    alu_op_e alu_op;

    assign opc      = if_instr[6:0];
    assign f3       = if_instr[14:12];
    assign is_lui   = opc == OPC_LUI;
    assign is_auipc = opc == OPC_AUIPC;
    assign is_jal   = opc == OPC_JAL;
    assign is_jalr  = opc == OPC_JALR;
    assign is_br    = opc == OPC_BRANCH;
    assign is_ld    = opc == OPC_LOAD;
    assign is_st    = opc == OPC_STORE;
    assign is_opi   = opc == OPC_OPIMM;
    assign is_op    = opc == OPC_OP;
    assign legal    = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_opi | is_op;
    assign wb       = legal & ~is_br & ~is_st;

    assign rs1_addr = (is_lui | is_auipc | is_jal) ? 5'd0 : if_instr[19:15];
    assign rs2_addr = (is_br | is_st | is_op) ? if_instr[24:20] : 5'd0;
    assign rs1_val  = rs1_addr == 5'd0 ? '0 : (wb_en && wb_rd == rs1_addr) ? wb_data : rs1_rdata;
    assign rs2_val  = rs2_addr == 5'd0 ? '0 : (wb_en && wb_rd == rs2_addr) ? wb_data : rs2_rdata;

    assign hazard   = id_valid && id_mem_rd && id_rd != 5'd0 && (id_rd == rs1_addr || id_rd == rs2_addr);
    assign if_ready = !flush && !hazard && (!id_valid || id_ready);
    assign accept   = if_valid && if_ready;

    imm_gen #(.WIDTH(WIDTH)) u_imm_gen (.instr(if_instr), .imm(imm));

    always_comb begin
        alu_op = ALU_ADD;
        if (is_lui)
            alu_op = ALU_PASS_B;
        else if (is_op || is_opi)
            case (f3)
                3'b000:  alu_op = (is_op && if_instr[30]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = if_instr[30] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_rs1_val <= '0;
            id_rs2_val <= '0;
            id_imm     <= '0;
            id_rd      <= '0;
            id_alu_op  <= '0;
            id_funct3  <= '0;
            id_wb_en   <= 1'b0;
            id_mem_rd  <= 1'b0;
            id_mem_wr  <= 1'b0;
            id_branch  <= 1'b0;
            id_jump    <= 1'b0;
            id_illegal <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (accept) begin
            id_valid   <= 1'b1;
            id_pc      <= if_pc;
            id_rs1_val <= rs1_val;
            id_rs2_val <= rs2_val;
            id_imm     <= imm;
            id_rd      <= wb ? if_instr[11:7] : 5'd0;
            id_alu_op  <= alu_op;
            id_funct3  <= f3;
            id_wb_en   <= wb;
            id_mem_rd  <= is_ld;
            id_mem_wr  <= is_st;
            id_branch  <= is_br;
            id_jump    <= is_jal | is_jalr;
            id_illegal <= ~legal;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed scoreboard bench for decode_stage
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0, if_valid = 1'b0, wb_en = 1'b0, id_ready = 1'b0;
    logic if_ready, id_valid;
    logic [31:0] if_instr = '0, if_pc = '0, wb_data = '0;
    logic [4:0] wb_rd = '0;
    logic [4:0] rs1_addr, rs2_addr, id_rd;
    logic [31:0] rs1_rdata, rs2_rdata, id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [3:0] id_alu_op;
    logic [2:0] id_funct3;
    logic id_wb_en, id_mem_rd, id_mem_wr, id_branch, id_jump, id_illegal;

    typedef struct {
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  a1, a2, rd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [5:0]  fl;
        bit          ci, ca;
    } exp_t;

    logic [31:0] rf [32];
    exp_t sb[$];
    exp_t cur;
    bit mv;
    int passed = 0, total = 0;

    assign rs1_rdata = rf[rs1_addr];
    assign rs2_rdata = rf[rs2_addr];

    always #5 clk = ~clk;

    decode_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
        .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_rd == a) return wb_data;
        return rf[a];
    endfunction

    // Reference decode built straight from the RV32I field definitions
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        bit lui, u, j, jr, br, ld, st, oi, rr, legal, wb;
        op = ins[6:0];
        f3 = ins[14:12];
        lui = op == 7'h37;
        u = lui || op == 7'h17;
        j = op == 7'h6F;
        jr = op == 7'h67;
        br = op == 7'h63;
        ld = op == 7'h03;
        st = op == 7'h23;
        oi = op == 7'h13;
        rr = op == 7'h33;
        legal = u || j || jr || br || ld || st || oi || rr;
        wb = legal && !br && !st;
        e.pc = pc;
        e.a1 = (u || j) ? 5'd0 : ins[19:15];
        e.a2 = (br || st || rr) ? ins[24:20] : 5'd0;
        e.r1 = opnd(e.a1);
        e.r2 = opnd(e.a2);
        if (u) e.imm = {ins[31:12], 12'b0};
        else if (j) e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        else if (br) e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        else if (st) e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        else e.imm = {{20{ins[31]}}, ins[31:20]};
        case (f3)
            3'd0: e.alu = (rr && ins[30]) ? 4'd1 : 4'd0;
            3'd1: e.alu = 4'd2;
            3'd2: e.alu = 4'd3;
            3'd3: e.alu = 4'd4;
            3'd4: e.alu = 4'd5;
            3'd5: e.alu = ins[30] ? 4'd7 : 4'd6;
            3'd6: e.alu = 4'd8;
            default: e.alu = 4'd9;
        endcase
        if (lui) e.alu = 4'd10;
        else if (!(oi || rr)) e.alu = 4'd0;
        e.ci = legal && !rr;
        e.ca = legal && !br;
        e.rd = wb ? ins[11:7] : 5'd0;
        e.f3 = f3;
        e.fl = {wb, ld, st, br, j || jr, !legal};
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v, input logic fl,
                        input logic rdy, input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        exp_t e;
        bit hz, er;
        if_instr = ins; if_pc = pc; if_valid = v; flush = fl; id_ready = rdy;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        e = model(ins, pc);
        hz = mv && cur.fl[4] && cur.rd != 5'd0 && (cur.rd == e.a1 || cur.rd == e.a2);
        er = !fl && !hz && (!mv || rdy);
        #2;
        chk("if_ready", {31'd0, if_ready}, {31'd0, er});
        chk("id_valid", {31'd0, id_valid}, {31'd0, mv});
        chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, e.a1});
        chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, e.a2});
        @(posedge clk);
        if (fl) mv = 1'b0;
        else if (v && er) begin
            mv = 1'b1;
            cur = e;
            sb.push_back(e);
        end else if (rdy) mv = 1'b0;
        #1;
        if (we && wrd != 5'd0) rf[wrd] = wd;
    endtask

    task automatic do_reset();
        if_valid = 1'b0; flush = 1'b0; id_ready = 1'b0; wb_en = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        mv = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 9))
            0: ins[6:0] = 7'h37;
            1: ins[6:0] = 7'h17;
            2: ins[6:0] = 7'h6F;
            3: ins[6:0] = 7'h67;
            4: ins[6:0] = 7'h63;
            5: ins[6:0] = 7'h03;
            6: ins[6:0] = 7'h23;
            7: ins[6:0] = 7'h13;
            8: ins[6:0] = 7'h33;
            default: ;
        endcase
        ins[11:7] = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        if (ins[6:0] == 7'h33) ins[31:25] = ins[30] ? 7'h20 : 7'h00;
        return ins;
    endfunction

    // Monitor: every presented bundle is compared to the scoreboard head
    always @(negedge clk) begin
        if (rst && id_valid) begin
            if (sb.size() == 0) chk("unexpected_bundle", {31'd0, id_valid}, 32'd0);
            else begin
                exp_t f;
                f = sb[0];
                chk("id_pc", id_pc, f.pc);
                chk("id_rs1_val", id_rs1_val, f.r1);
                chk("id_rs2_val", id_rs2_val, f.r2);
                chk("id_rd", {27'd0, id_rd}, {27'd0, f.rd});
                chk("id_funct3", {29'd0, id_funct3}, {29'd0, f.f3});
                chk("id_flags", {26'd0, id_wb_en, id_mem_rd, id_mem_wr, id_branch, id_jump, id_illegal},
                    {26'd0, f.fl});
                if (f.ci) chk("id_imm", id_imm, f.imm);
                if (f.ca) chk("id_alu_op", {28'd0, id_alu_op}, {28'd0, f.alu});
                if (id_ready || flush) void'(sb.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD;
        mv = 1'b0;
        do_reset();
        step(32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0);
        chk("rst_id_rd", {27'd0, id_rd}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_imm", id_imm, 32'd0);
        step(32'hFFF00293, 32'h100, 1, 0, 1, 0, 5'd0, 32'h0);
        chk("addi_valid", {31'd0, id_valid}, 32'd1);
        chk("addi_imm", id_imm, 32'hFFFFFFFF);
        chk("addi_rd", {27'd0, id_rd}, 32'd5);
        chk("addi_alu", {28'd0, id_alu_op}, 32'd0);
        chk("addi_wb", {31'd0, id_wb_en}, 32'd1);
        chk("addi_rs1", id_rs1_val, 32'd0);
        rf[2] = 32'd9;
        step(32'h002081B3, 32'h104, 1, 0, 1, 1, 5'd1, 32'd7);
        chk("byp_rs1", id_rs1_val, 32'd7);
        chk("byp_rs2", id_rs2_val, 32'd9);
        step(32'h002001B3, 32'h108, 1, 0, 1, 1, 5'd0, 32'd7);
        chk("x0_rs1", id_rs1_val, 32'd0);
        step(32'h0000A203, 32'h10C, 1, 0, 1, 0, 5'd0, 32'h0);
        step(32'h00420333, 32'h110, 1, 0, 1, 0, 5'd0, 32'h0);
        chk("bubble", {31'd0, id_valid}, 32'd0);
        step(32'h00420333, 32'h110, 1, 0, 1, 0, 5'd0, 32'h0);
        chk("after_bubble_rd", {27'd0, id_rd}, 32'd6);
        step(32'h0000A003, 32'h114, 1, 0, 1, 0, 5'd0, 32'h0);
        step(32'h00000333, 32'h118, 1, 0, 1, 0, 5'd0, 32'h0);
        chk("no_bubble", {31'd0, id_valid}, 32'd1);
        chk("no_bubble_pc", id_pc, 32'h118);
        step(32'hFFF00293, 32'h11C, 1, 0, 1, 0, 5'd0, 32'h0);
        step(32'h00000333, 32'h120, 1, 0, 0, 0, 5'd0, 32'h0);
        chk("stall_pc", id_pc, 32'h11C);
        step(32'h00000333, 32'h120, 1, 1, 0, 0, 5'd0, 32'h0);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        step(32'h00000333, 32'h120, 1, 0, 0, 0, 5'd0, 32'h0);
        chk("post_flush_pc", id_pc, 32'h120);
        step(32'h0000007F, 32'h124, 1, 0, 1, 0, 5'd0, 32'h0);
        chk("ill_flag", {31'd0, id_illegal}, 32'd1);
        chk("ill_wb", {31'd0, id_wb_en}, 32'd0);
        step(32'hFE000EE3, 32'h128, 1, 0, 1, 0, 5'd0, 32'h0);
        chk("beq_imm", id_imm, 32'hFFFFFFFC);
        chk("beq_branch", {31'd0, id_branch}, 32'd1);
        step(32'hFFF00293, 32'h12C, 1, 0, 0, 0, 5'd0, 32'h0);
        do_reset();
        chk("midrst_valid", {31'd0, id_valid}, 32'd0);
        chk("midrst_rd", {27'd0, id_rd}, 32'd0);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(rnd_instr(), $urandom & 32'hFFFFFFFC, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end
        step(32'h0, 32'h0, 0, 0, 1, 0, 5'd0, 32'h0);
        step(32'h0, 32'h0, 0, 0, 1, 0, 5'd0, 32'h0);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction decode stage sitting between fetch and execute, directly upstream of the register file. It:
- drives the register-file read addresses from the incoming instruction and captures the returned operands;
- applies x0 forcing and write-back bypass;
- decodes control and immediate fields into a registered ID/EX bundle behind a valid/ready handshake;
- inserts one bubble on a load-use hazard.

## Interface
- WIDTH, 32, datapath/PC width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  kill in-flight bundle (branch redirect)
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  decode accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  WIDTH  instruction PC
- rs1_addr, rs2_addr  out  5  to register file read ports (combinational from if_instr)
- rs1_rdata, rs2_rdata  in  WIDTH  register file read data, same cycle
- wb_en  in  1  write-back this cycle
- wb_rd  in  5  write-back destination
- wb_data  in  WIDTH  write-back value
- id_valid  out  1  bundle valid
- id_ready  in  1  execute accepts bundle
- id_pc, id_rs1_val, id_rs2_val, id_imm  out  WIDTH  registered operands and sign-extended immediate
- id_rd  out  5  destination, 0 if no write
- id_alu_op  out  4  package ALU opcode
- id_funct3  out  3  raw funct3 (branch/load/store size)
- id_wb_en, id_mem_rd, id_mem_wr, id_branch, id_jump, id_illegal  out  1  control flags

## Operation
- Opcode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Anything else sets id_illegal=1, id_wb_en=0, id_rd=0, all memory/branch flags 0.
- Address forcing: rs1_addr=if_instr[19:15] except forced 0 for LUI/AUIPC/JAL. rs2_addr=if_instr[24:20] only for BRANCH/STORE/OP, else 0.
- Operand select, per port, in priority order:
  - address 0 gives 0;
  - else if wb_en && wb_rd==addr, use wb_data;
  - else use rdata.
- Immediates sign-extended to WIDTH: I, S, B (bit0=0), U (low 12 bits 0), J (bit0=0).
- id_alu_op: SUB only for OP with funct7[5]=1 and funct3=000. SRA for funct3=101 with funct7[5]=1 (OP and OP-IMM). LUI gives PASS_B. AUIPC/JAL/JALR/LOAD/STORE give ADD.
- Accept condition: if_valid && if_ready.
  - if_ready = !flush && !hazard && (!id_valid || id_ready).
- Load-use hazard: id_valid && id_mem_rd && id_rd!=0 && (id_rd==rs1_addr || id_rd==rs2_addr), evaluated on forced addresses.
- Pipeline register update per edge, in priority order:
  - reset;
  - flush: id_valid←0;
  - accept: load bundle, id_valid←1;
  - id_ready: id_valid←0;
  - otherwise hold.
- Reset: id_valid=0 and every id_* output 0; mid-operation reset drops the bundle.

## Timing
- Accept at edge N gives id_valid=1 after edge N. Throughput 1 instruction/cycle when id_ready is held high.
- Bundle is stable while id_valid && !id_ready.
- Load-use costs exactly one bubble:
  - load consumed at edge N;
  - dependent instruction accepted at edge N+1;
  - id_valid=0 for the cycle between.
- Flush and accept in the same cycle: flush wins and if_ready=0.
- Flush with id_valid && id_ready: bundle counts as consumed, id_valid←0.
- wb bypass covers only the same-cycle write; earlier writes come from the register file.
- if_ready, rs*_addr and the hazard are combinational from if_instr and registered state. No path from id_ready to id_valid within a cycle.

## Structure
- Shared package rv_pkg holds:
  - opcode constants (7'b0110111 …);
  - ALU op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10;
  - immediate-format enum I/S/B/U/J.
- Sub-module imm_gen: combinational instr → sign-extended immediate, reused by the branch predictor later.

## Test plan
- After reset, first cycle: id_valid=0, id_rd=0, if_ready=1.
- ADDI x5,x0,-1 (0xFFF00293) accepted at pc 0x100 → next cycle: id_imm=0xFFFFFFFF, id_rd=5, id_alu_op=ADD, id_wb_en=1, id_rs1_val=0 even with rs1_rdata=0xDEAD.
- ADD x3,x1,x2 with wb_en=1, wb_rd=1, wb_data=7 same cycle, rs2_rdata=9 → id_rs1_val=7, id_rs2_val=9. Same with wb_rd=0 → x0 stays 0.
- LW x4,0(x1), then ADD x6,x4,x4 with id_ready=1 → exactly one id_valid=0 cycle between the two bundles. ADD with rd of LW =0 → no bubble.
- id_ready=0 for 3 cycles with if_valid=1 → if_ready=0, bundle unchanged. Flush asserted on cycle 2 → id_valid=0 next cycle, nothing accepted that cycle.
- Word 0x0000007F → id_illegal=1, id_wb_en=0. BEQ with offset −4 (0xFE000EE3) → id_imm=0xFFFFFFFC, id_branch=1.
